// File: rtl/pciecfg_mgmt_resp.sv
// Purpose: config-management responder holding NUM_DW dwords; DW0/DW2 read-only, out-of-range reads return zero.
// Latency: done pulses LATENCY cycles after the request is captured; do, registers and counters update on that edge.
// Backpressure: rd_en/wr_en are level requests held by the requester; a new request is taken only after both drop.
module pciecfg_mgmt_resp #(
    parameter int          LATENCY   = 2,
    parameter int          NUM_DW    = 64,
    parameter logic [15:0] VENDOR_ID = 16'h10EE,
    parameter logic [15:0] DEVICE_ID = 16'h7028,
    parameter logic [31:0] CLASS_REV = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_dwaddr,
    input  logic        cfg_mgmt_rd_en,
    input  logic        cfg_mgmt_wr_en,
    input  logic [3:0]  cfg_mgmt_byte_en,
    input  logic [31:0] cfg_mgmt_di,
    output logic [31:0] cfg_mgmt_do,
    output logic        cfg_mgmt_rd_wr_done,
    output logic        proto_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] di_q, di_d;
    logic        op_rd_q, op_rd_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] do_q, do_d;
    logic        perr_q, perr_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] regs_q [NUM_DW];
    logic [31:0] regs_d [NUM_DW];
    logic [31:0] rd_data;

    function automatic logic [31:0] rst_val(input int idx);
        if (idx == 0)      return {DEVICE_ID, VENDOR_ID};
        else if (idx == 2) return CLASS_REV;
        else               return 32'h0;
    endfunction

    // Addresses beyond NUM_DW match no entry and read back as zero.
    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < NUM_DW; i++) begin
            if (addr_q == 10'(i)) rd_data = regs_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        di_d     = di_q;
        op_rd_d  = op_rd_q;
        op_wr_d  = op_wr_q;
        do_d     = do_q;
        perr_d   = perr_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
                    addr_d  = cfg_mgmt_dwaddr;
                    be_d    = cfg_mgmt_byte_en;
                    di_d    = cfg_mgmt_di;
                    op_rd_d = cfg_mgmt_rd_en;
                    op_wr_d = cfg_mgmt_wr_en;
                    cnt_d   = 4'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d = DONE;
                    if (op_rd_q && op_wr_q) begin
                        perr_d = 1'b1;
                        do_d   = 32'hFFFF_FFFF;
                    end else if (op_rd_q) begin
                        do_d     = rd_data;
                        rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
                    end else begin
                        wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                        // DW0 and DW2 are identity registers and never take writes.
                        for (int i = 0; i < NUM_DW; i++) begin
                            if (addr_q == 10'(i) && i != 0 && i != 2) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (be_q[b]) regs_d[i][8*b +: 8] = di_q[8*b +: 8];
                                end
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!cfg_mgmt_rd_en && !cfg_mgmt_wr_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 10'd0;
            be_q     <= 4'd0;
            di_q     <= 32'h0;
            op_rd_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            do_q     <= 32'h0;
            perr_q   <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
            for (int i = 0; i < NUM_DW; i++) regs_q[i] <= rst_val(i);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            di_q     <= di_d;
            op_rd_q  <= op_rd_d;
            op_wr_q  <= op_wr_d;
            do_q     <= do_d;
            perr_q   <= perr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            regs_q   <= regs_d;
        end
    end

    assign cfg_mgmt_do         = do_q;
    assign cfg_mgmt_rd_wr_done = (state_q == DONE);
    assign proto_err           = perr_q;
    assign rd_cnt              = rd_cnt_q;
    assign wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_pciecfg_mgmt_resp.sv
// Bench for pciecfg_mgmt_resp: directed scenarios followed by randomized requests,
// each compared against a dword-array reference model of the responder.
module tb_pciecfg_mgmt_resp;

    localparam int LAT = 2;
    localparam int NDW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] di = '0;
    logic [31:0] dout;
    logic        done;
    logic        perr;
    logic [15:0] rdc;
    logic [15:0] wrc;

    int compared = 0;
    int mism = 0;

    logic [31:0] mem [NDW];
    logic [31:0] m_do;
    logic        m_perr;
    int          m_rd;
    int          m_wr;

    pciecfg_mgmt_resp #(
        .LATENCY(LAT), .NUM_DW(NDW), .VENDOR_ID(16'h10EE),
        .DEVICE_ID(16'h7028), .CLASS_REV(32'h0200_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_mgmt_dwaddr(addr), .cfg_mgmt_rd_en(rd_en), .cfg_mgmt_wr_en(wr_en),
        .cfg_mgmt_byte_en(be), .cfg_mgmt_di(di), .cfg_mgmt_do(dout),
        .cfg_mgmt_rd_wr_done(done), .proto_err(perr), .rd_cnt(rdc), .wr_cnt(wrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDW; i++) mem[i] = 32'h0;
        mem[0] = 32'h7028_10EE;
        mem[2] = 32'h0200_0000;
        m_do = 32'h0; m_perr = 1'b0; m_rd = 0; m_wr = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_apply(input logic r, input logic w, input logic [9:0] a,
                               input logic [3:0] b, input logic [31:0] d);
        int ai;
        ai = int'(a);
        if (r && w) begin
            m_perr = 1'b1;
            m_do   = 32'hFFFF_FFFF;
        end else if (r) begin
            m_do = (ai < NDW) ? mem[ai] : 32'h0;
            m_rd = sat_inc(m_rd);
        end else begin
            if (ai < NDW && ai != 0 && ai != 2)
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem[ai][8*i +: 8] = d[8*i +: 8];
            m_wr = sat_inc(m_wr);
        end
    endtask

    // Called on a falling edge; the next rising edge is the capture edge.
    task automatic txn(input logic r, input logic w, input logic [9:0] a, input logic [3:0] b,
                       input logic [31:0] d, input int hold, input bit scramble);
        int first;
        int pulses;
        first = -1;
        pulses = 0;
        rd_en = r; wr_en = w; addr = a; be = b; di = d;
        model_apply(r, w, a, b, d);
        for (int c = 1; c <= LAT + hold + 6; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (first < 0 && scramble) begin
                addr = 10'($urandom); be = 4'($urandom); di = $urandom;
            end
            if (first >= 0 && c >= first + hold) begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        chk("done_latency", 32'(first), 32'(LAT + 1));
        chk("done_pulses", 32'(pulses), 32'd1);
        chk("do", dout, m_do);
        chk("proto_err", 32'(perr), 32'(m_perr));
        chk("rd_cnt", 32'(rdc), 32'(m_rd));
        chk("wr_cnt", 32'(wrc), 32'(m_wr));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_do"}, dout, 32'h0);
        chk({tag, "_perr"}, 32'(perr), 32'd0);
        chk({tag, "_rdcnt"}, 32'(rdc), 32'd0);
        chk({tag, "_wrcnt"}, 32'(wrc), 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Read identity dword on the very first edge after reset release.
        txn(1'b1, 1'b0, 10'd0, 4'h0, 32'h0, 0, 1'b0);
        chk("dw0_read", dout, 32'h7028_10EE);
        chk("dw0_rdcnt", 32'(rdc), 32'd1);

        // Masked write, with inputs disturbed while waiting.
        txn(1'b0, 1'b1, 10'd4, 4'b0101, 32'hAABB_CCDD, 0, 1'b1);
        txn(1'b1, 1'b0, 10'd4, 4'h0, 32'h0, 0, 1'b0);
        chk("dw4_masked", dout, 32'h00BB_00DD);
        chk("dw4_wrcnt", 32'(wrc), 32'd1);

        // Read-only identity and out-of-range address.
        txn(1'b0, 1'b1, 10'd0, 4'hF, 32'hFFFF_FFFF, 0, 1'b0);
        txn(1'b1, 1'b0, 10'd0, 4'h0, 32'h0, 0, 1'b0);
        chk("dw0_readonly", dout, 32'h7028_10EE);
        txn(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0, 0, 1'b0);
        chk("oor_read", dout, 32'h0);

        // Protocol error: both enables at capture.
        txn(1'b1, 1'b1, 10'd4, 4'hF, 32'h1234_5678, 0, 1'b0);
        chk("perr_flag", 32'(perr), 32'd1);
        chk("perr_do", dout, 32'hFFFF_FFFF);
        txn(1'b1, 1'b0, 10'd4, 4'h0, 32'h0, 0, 1'b0);
        chk("perr_dw4", dout, 32'h00BB_00DD);

        // Held request yields a single completion.
        txn(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 3, 1'b0);
        chk("held_dw2", dout, 32'h0200_0000);

        // Reset during WAIT of a write aborts it.
        rd_en = 1'b0; wr_en = 1'b1; addr = 10'd4; be = 4'hF; di = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_done_held", 32'(done), 32'd0);
        rst = 1'b0;
        txn(1'b1, 1'b0, 10'd4, 4'h0, 32'h0, 0, 1'b0);
        chk("abort_dw4", dout, 32'h0);

        // Randomized traffic against the model.
        repeat (300) begin
            int sel;
            logic r, w;
            logic [9:0] a;
            sel = $urandom_range(0, 9);
            r = (sel < 5) || (sel == 9);
            w = (sel >= 5);
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            txn(r, w, a, 4'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/pciecfg_mgmt_resp.md
PCIECFG_MGMT_RESP -- requirements
Module: pciecfg_mgmt_resp

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request capture to done; legal range 1..15.
REQ-003 SHALL have parameter NUM_DW, default 64: implemented config dwords, at addresses 0..NUM_DW-1.
REQ-004 SHALL have parameter VENDOR_ID, default 16'h10EE: reset value of DW0[15:0].
REQ-005 SHALL have parameter DEVICE_ID, default 16'h7028: reset value of DW0[31:16].
REQ-006 SHALL have parameter CLASS_REV, default 32'h0200_0000: reset value of DW2.
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port cfg_mgmt_dwaddr, input, 10 bits: dword address.
REQ-010 SHALL have port cfg_mgmt_rd_en, input, 1 bit: read request level, held until done.
REQ-011 SHALL have port cfg_mgmt_wr_en, input, 1 bit: write request level, held until done.
REQ-012 SHALL have port cfg_mgmt_byte_en, input, 4 bits: write byte enables; bit i selects byte i.
REQ-013 SHALL have port cfg_mgmt_di, input, 32 bits: write data.
REQ-014 SHALL have port cfg_mgmt_do, output, 32 bits: read data.
REQ-015 SHALL have port cfg_mgmt_rd_wr_done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port proto_err, output, 1 bit: sticky protocol-error flag.
REQ-017 SHALL have port rd_cnt, output, 16 bits: saturating count of completed reads.
REQ-018 SHALL have port wr_cnt, output, 16 bits: saturating count of completed writes.

Function
REQ-019 SHALL implement the states IDLE, WAIT, DONE and RELEASE.
REQ-020 In IDLE, when rd_en or wr_en is high at a clock edge k, the block SHALL capture dwaddr, byte_en, di and the operation type, then enter WAIT.
REQ-021 WAIT SHALL count LATENCY-1 cycles and then enter DONE; with LATENCY=1 it SHALL enter DONE directly at edge k+1.
REQ-022 cfg_mgmt_rd_wr_done SHALL be high for exactly the one cycle spent in DONE, starting at edge k+LATENCY.
REQ-023 Register update and cfg_mgmt_do update SHALL occur on the edge that enters DONE.
REQ-024 cfg_mgmt_do SHALL then hold its value until the next read completes.
REQ-025 The block SHALL leave DONE for RELEASE.
REQ-026 The block SHALL stay in RELEASE until rd_en and wr_en are both low, then return to IDLE.
REQ-027 A request SHALL never be accepted in WAIT, DONE or RELEASE.
REQ-028 A write SHALL update only the bytes whose byte_en bit is set.
REQ-029 byte_en=4'h0 SHALL complete normally with no data change and SHALL count as a write.
REQ-030 DW0 and DW2 SHALL be read-only: writes to them complete and count, but change nothing.
REQ-031 An address >= NUM_DW SHALL complete normally: a read returns 32'h0 and a write is discarded.
REQ-032 rd_en and wr_en both high at capture SHALL be a protocol error with the following response:
- proto_err is set (sticky);
- no register changes;
- cfg_mgmt_do = 32'hFFFF_FFFF;
- done still pulses;
- neither counter increments.
REQ-033 Changes to input values during WAIT SHALL be ignored; the captured values are used.
REQ-034 rd_cnt and wr_cnt SHALL increment on the DONE-entry edge of their respective operations and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-035 Asserting rst SHALL immediately, without a clock, apply these values:
- state = IDLE;
- rd_wr_done = 0;
- cfg_mgmt_do = 0;
- proto_err = 0;
- rd_cnt = 0 and wr_cnt = 0;
- DW0 = {DEVICE_ID, VENDOR_ID};
- DW2 = CLASS_REV;
- all other dwords = 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no done pulse and no register write.
REQ-037 After reset is released, a request SHALL be accepted on the first clock edge.

Verification
REQ-038 Read test (LATENCY=2): rd_en=1, dwaddr=0 at edge k -> done=1 only in the cycle after edge k+2; do=32'h7028_10EE; rd_cnt=1.
REQ-039 Masked write test: write DW4 with di=32'hAABB_CCDD and byte_en=4'b0101, then read DW4 -> do=32'h00BB_00DD; wr_cnt=1.
REQ-040 Read-only and out-of-range test: write DW0 with 32'hFFFF_FFFF and byte_en=4'hF -> DW0 still reads 32'h7028_10EE; a read of dwaddr=10'h3FF -> do=0 and done pulses.
REQ-041 Protocol-error test: rd_en=wr_en=1 with dwaddr=4 -> proto_err=1, do=32'hFFFF_FFFF, DW4 unchanged, both counters unchanged.
REQ-042 Held-request test: hold rd_en high for 3 cycles after done -> exactly one done pulse and rd_cnt increments by exactly 1.
REQ-043 Reset-abort test: assert rst during WAIT of a write to DW4 -> no done pulse, DW4=0, and all outputs at their reset values.
